branch_predictor: RTL

//  Fetch-stage gshare direction predictor plus direct-mapped BTB, directly upstream of FD_reg.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/bp_btb.sv | 53 +++++
 rtl/branch_predictor.sv | 98 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: BTB entry layout, PHT reset value, default history length.
// Zero latency (types and constants only); no flow control.
// No backpressure: nothing here holds state.
package cpu_pkg;

    localparam int GHR_BITS_DEFAULT    = 8;
    localparam int BTB_ENTRIES_DEFAULT = 16;
    localparam int BTB_TAG_MAX         = 30;

    localparam logic [1:0] PHT_WEAK_NT = 2'b01;

    // Tag field sized for the smallest legal BTB; unused upper bits stay zero.
    typedef struct packed {
        logic                   valid;
        logic [BTB_TAG_MAX-1:0] tag;
        logic [31:0]            target;
        logic                   is_jump;
    } btb_entry_t;

    function automatic logic [BTB_TAG_MAX-1:0] btb_tag(input logic [31:0] pc, input int idx_w);
        logic [31:0] shifted;
        shifted = pc >> (2 + idx_w);
        return shifted[BTB_TAG_MAX-1:0];
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer indexed by PC[2+:log2(ENTRIES)].
// Combinational read, write lands on the next clk edge (read-before-write).
// No backpressure: a write is accepted every cycle wr_en is high.
module bp_btb
    import cpu_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rd_pc,
    output logic        rd_hit,
    output logic [31:0] rd_target,
    output logic        rd_is_jump,
    input  logic        wr_en,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_target,
    input  logic        wr_is_jump
);

    localparam int IDX_W = $clog2(ENTRIES);

    btb_entry_t           mem [ENTRIES];
    logic [IDX_W-1:0]     rd_idx;
    logic [IDX_W-1:0]     wr_idx;
    btb_entry_t           rd_entry;

    assign rd_idx   = rd_pc[2 +: IDX_W];
    assign wr_idx   = wr_pc[2 +: IDX_W];
    assign rd_entry = mem[rd_idx];

    assign rd_hit     = rd_entry.valid && (rd_entry.tag == btb_tag(rd_pc, IDX_W));
    assign rd_target  = rd_hit ? rd_entry.target : 32'h0;
    assign rd_is_jump = rd_hit && rd_entry.is_jump;

    // Byte-offset bits never select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= '{valid:   1'b1,
                             tag:     btb_tag(wr_pc, IDX_W),
                             target:  wr_target,
                             is_jump: wr_is_jump};
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage gshare predictor + BTB; optional stats counters under BP_STATS_EN.
// Lookup is zero latency; training from EX lands on the next clk edge.
// No backpressure: updates are taken every cycle E_update is high, regardless of stalls.
module branch_predictor
    import cpu_pkg::*;
#(
    parameter int GHR_BITS    = GHR_BITS_DEFAULT,
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         F_PC,
    output logic                F_pred_taken,
    output logic [GHR_BITS-1:0] F_pht_idx,
    output logic                F_btb_hit,
    output logic [31:0]         F_btb_target,
    output logic [31:0]         F_pred_pc,
    input  logic                E_update,
    input  logic                E_is_cond,
    input  logic [31:0]         E_PC,
    input  logic [GHR_BITS-1:0] E_pht_idx,
    input  logic                E_taken,
    input  logic [31:0]         E_target,
    input  logic                E_mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0]         bp_branch_cnt,
    output logic [31:0]         bp_mispredict_cnt
`endif
);

    localparam int PHT_SIZE = 1 << GHR_BITS;

    logic [1:0]          pht [PHT_SIZE];
    logic [GHR_BITS-1:0] ghr;
    logic                btb_is_jump;
    logic [1:0]          upd_ctr;
    logic [1:0]          upd_ctr_next;

    bp_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rd_pc      (F_PC),
        .rd_hit     (F_btb_hit),
        .rd_target  (F_btb_target),
        .rd_is_jump (btb_is_jump),
        .wr_en      (E_update && E_taken),
        .wr_pc      (E_PC),
        .wr_target  (E_target),
        .wr_is_jump (~E_is_cond)
    );

    assign F_pht_idx    = F_PC[2 +: GHR_BITS] ^ ghr;
    assign F_pred_taken = F_btb_hit && (btb_is_jump || pht[F_pht_idx][1]);
    assign F_pred_pc    = F_pred_taken ? F_btb_target : (F_PC + 32'd4);

    assign upd_ctr = pht[E_pht_idx];

    always_comb begin
        upd_ctr_next = upd_ctr;
        if (E_taken) begin
            if (upd_ctr != 2'b11) upd_ctr_next = upd_ctr + 2'b01;
        end else begin
            if (upd_ctr != 2'b00) upd_ctr_next = upd_ctr - 2'b01;
        end
    end

    // History is trained non-speculatively from resolved conditionals only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
            for (int i = 0; i < PHT_SIZE; i++) begin
                pht[i] <= PHT_WEAK_NT;
            end
        end else if (E_update && E_is_cond) begin
            pht[E_pht_idx] <= upd_ctr_next;
            ghr            <= {ghr[GHR_BITS-2:0], E_taken};
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_branch_cnt     <= '0;
            bp_mispredict_cnt <= '0;
        end else if (E_update) begin
            bp_branch_cnt <= bp_branch_cnt + 32'd1;
            if (E_mispredict) bp_mispredict_cnt <= bp_mispredict_cnt + 32'd1;
        end
    end
`else
    logic unused_mispredict;
    assign unused_mispredict = E_mispredict;
`endif

endmodule
